// File: rtl/mouse_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mouse_click_decoder
// Description : Filters the PS/2 left button, validates press/release inside
//               one cell of a 3x3 board and offers the cell (0..8) as a move
//               over a valid/ready handshake.
//               Optional macro HOVER_CELL_EN adds a registered hover_cell.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_click_decoder #(
    parameter int X0       = 160,
    parameter int Y0       = 80,
    parameter int CELL_W   = 100,
    parameter int CELL_H   = 100,
    parameter int HOLD_MIN = 4
) (
    input  logic       CLK_100MHZ,
    input  logic       reset,
    input  logic [9:0] posX,
    input  logic [8:0] posY,
    input  logic [2:0] buttons,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_cell,
    output logic [3:0] hover_cell
);

    localparam int               c_CNT_W = $clog2(HOLD_MIN + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD = c_CNT_W'(HOLD_MIN);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [10:0] c_X0 = 11'(X0);
    localparam logic [10:0] c_X1 = 11'(X0 + CELL_W);
    localparam logic [10:0] c_X2 = 11'(X0 + 2 * CELL_W);
    localparam logic [10:0] c_X3 = 11'(X0 + 3 * CELL_W);
    localparam logic [10:0] c_Y0 = 11'(Y0);
    localparam logic [10:0] c_Y1 = 11'(Y0 + CELL_H);
    localparam logic [10:0] c_Y2 = 11'(Y0 + 2 * CELL_H);
    localparam logic [10:0] c_Y3 = 11'(Y0 + 3 * CELL_H);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS    = 2'd1,
        S_PENDING  = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_btn_f;
    logic                 r_btn_d;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_latched;
    logic [3:0]           r_move_cell;
    logic                 w_latch_en;
    logic                 w_load_move;
    logic                 w_rise;
    logic                 w_fall;
    logic [10:0]          w_x;
    logic [10:0]          w_y;
    logic [1:0]           w_col;
    logic [1:0]           w_row;
    logic                 w_inside;
    logic [3:0]           w_cell;
    logic                 w_unused;

    assign w_unused = &{1'b0, buttons[2:1]};

    // Button filter: btn_f only follows a raw level held for HOLD_MIN+1 cycles
    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) begin
            r_btn_f <= 1'b0;
            r_btn_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_btn_d <= r_btn_f;
            if (buttons[0] == r_btn_f) begin
                r_cnt <= '0;
            end else if (r_cnt == c_HOLD) begin
                r_btn_f <= ~r_btn_f;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign w_rise = r_btn_f & ~r_btn_d;
    assign w_fall = ~r_btn_f & r_btn_d;

    // Threshold compare instead of division
    assign w_x      = {1'b0, posX};
    assign w_y      = {2'b00, posY};
    assign w_col    = (w_x < c_X1) ? 2'd0 : (w_x < c_X2) ? 2'd1 : 2'd2;
    assign w_row    = (w_y < c_Y1) ? 2'd0 : (w_y < c_Y2) ? 2'd1 : 2'd2;
    assign w_inside = (w_x >= c_X0) && (w_x < c_X3) && (w_y >= c_Y0) && (w_y < c_Y3);
    assign w_cell   = {2'b00, w_row} * 4'd3 + {2'b00, w_col};

    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_latched   <= 4'd0;
            r_move_cell <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_latch_en) r_latched <= w_cell;
            if (w_load_move) r_move_cell <= r_latched;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_latch_en  = 1'b0;
        w_load_move = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    if (w_inside) begin
                        w_next     = S_PRESS;
                        w_latch_en = 1'b1;
                    end else begin
                        w_next = S_WAIT_REL;
                    end
                end
            end
            S_PRESS: begin
                if (w_fall) begin
                    if (w_inside && (w_cell == r_latched)) begin
                        w_next      = S_PENDING;
                        w_load_move = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_PENDING: begin
                if (move_ready) w_next = r_btn_f ? S_WAIT_REL : S_IDLE;
            end
            S_WAIT_REL: begin
                if (!r_btn_f) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign move_valid = (r_state == S_PENDING);
    assign move_cell  = r_move_cell;

`ifdef HOVER_CELL_EN
    logic [3:0] r_hover;

    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) r_hover <= 4'd15;
        else       r_hover <= w_inside ? w_cell : 4'd15;
    end

    assign hover_cell = r_hover;
`else
    assign hover_cell = 4'd15;
`endif

endmodule
`default_nettype wire
